// File: rtl/morse_pkg.sv
// Definitions shared by the Morse transmitter and receiver: element coding,
// ASCII constants and the link state encoding.
package morse_pkg;

    localparam logic ELEM_DOT  = 1'b0;
    localparam logic ELEM_DASH = 1'b1;

    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE,
        ST_GAP
    } state_t;

endpackage

// File: rtl/morse_lut.sv
// Morse symbol to ASCII lookup (A-Z, 0-9). The first element sits in the MSB
// of the i_len used bits; dot=0, dash=1.
module morse_lut
    import morse_pkg::*;
#(
    parameter int MAX_ELEM = 5
) (
    input  logic [2:0]          i_len,
    input  logic [MAX_ELEM-1:0] i_pattern,
    output logic [7:0]          o_ascii,
    output logic                o_hit
);

    logic [4:0] w_low;
    logic [4:0] w_pat;
    logic [7:0] w_key;

    assign w_low = 5'(i_pattern);

    // Bits above the used length are masked so stale history can never alias a code.
    always_comb begin
        w_pat = '0;
        for (int i = 0; i < 5; i++) begin
            if (3'(i) < i_len) w_pat[i] = w_low[i];
        end
    end

    assign w_key = {i_len, w_pat};

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        o_ascii = ASCII_UNKNOWN;
        o_hit   = 1'b1;
        case (w_key)
            {3'd2, 5'b00001}: o_ascii = "A";
            {3'd4, 5'b01000}: o_ascii = "B";
            {3'd4, 5'b01010}: o_ascii = "C";
            {3'd3, 5'b00100}: o_ascii = "D";
            {3'd1, 5'b00000}: o_ascii = "E";
            {3'd4, 5'b00010}: o_ascii = "F";
            {3'd3, 5'b00110}: o_ascii = "G";
            {3'd4, 5'b00000}: o_ascii = "H";
            {3'd2, 5'b00000}: o_ascii = "I";
            {3'd4, 5'b00111}: o_ascii = "J";
            {3'd3, 5'b00101}: o_ascii = "K";
            {3'd4, 5'b00100}: o_ascii = "L";
            {3'd2, 5'b00011}: o_ascii = "M";
            {3'd2, 5'b00010}: o_ascii = "N";
            {3'd3, 5'b00111}: o_ascii = "O";
            {3'd4, 5'b00110}: o_ascii = "P";
            {3'd4, 5'b01101}: o_ascii = "Q";
            {3'd3, 5'b00010}: o_ascii = "R";
            {3'd3, 5'b00000}: o_ascii = "S";
            {3'd1, 5'b00001}: o_ascii = "T";
            {3'd3, 5'b00001}: o_ascii = "U";
            {3'd4, 5'b00001}: o_ascii = "V";
            {3'd3, 5'b00011}: o_ascii = "W";
            {3'd4, 5'b01001}: o_ascii = "X";
            {3'd4, 5'b01011}: o_ascii = "Y";
            {3'd4, 5'b01100}: o_ascii = "Z";
            {3'd5, 5'b11111}: o_ascii = "0";
            {3'd5, 5'b01111}: o_ascii = "1";
            {3'd5, 5'b00111}: o_ascii = "2";
            {3'd5, 5'b00011}: o_ascii = "3";
            {3'd5, 5'b00001}: o_ascii = "4";
            {3'd5, 5'b00000}: o_ascii = "5";
            {3'd5, 5'b10000}: o_ascii = "6";
            {3'd5, 5'b11000}: o_ascii = "7";
            {3'd5, 5'b11100}: o_ascii = "8";
            {3'd5, 5'b11110}: o_ascii = "9";
            default:          o_hit   = 1'b0;
        endcase
    end

endmodule

// File: rtl/morse_rx_decoder.sv
// Morse receiver: synchronises the keyed line, times marks and spaces in TICK
// units, and emits one ASCII character per letter gap plus one space per word gap.
module morse_rx_decoder
    import morse_pkg::*;
#(
    parameter int DOT_TICKS = 8,
    parameter int MAX_ELEM  = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TICK,
    input  logic       MORSE_IN,
    output logic [7:0] CHAR,
    output logic       VALID,
    output logic       ERR,
    output logic       BUSY
);

    localparam int CW = $clog2(5 * DOT_TICKS + 1);
    localparam logic [CW-1:0] C_DASH_TH   = CW'(2 * DOT_TICKS);
    localparam logic [CW-1:0] C_LETTER_TH = CW'(2 * DOT_TICKS);
    localparam logic [CW-1:0] C_WORD_TH   = CW'(5 * DOT_TICKS);
    localparam logic [CW-1:0] C_ONE       = CW'(1);
    localparam logic [2:0]    C_MAX_LEN   = 3'(MAX_ELEM);

    logic                r_sync1, r_sync2;
    state_t              r_state, w_state_nxt;
    logic [CW-1:0]       r_cnt, w_cnt_nxt, w_cnt_inc, w_cnt_start;
    logic [MAX_ELEM-1:0] r_pattern;
    logic [2:0]          r_len;
    logic                r_ovf;
    logic [7:0]          r_char, w_char_nxt;
    logic                r_valid, w_valid_nxt;
    logic                r_err, w_err_nxt;

    logic                w_lin;
    logic                w_elem;
    logic                w_end_mark;
    logic                w_emit_letter;
    logic                w_emit_space;
    logic [7:0]          w_lut_ascii;
    logic                w_lut_hit;

    morse_lut #(
        .MAX_ELEM (MAX_ELEM)
    ) u_lut (
        .i_len     (r_len),
        .i_pattern (r_pattern),
        .o_ascii   (w_lut_ascii),
        .o_hit     (w_lut_hit)
    );

    assign w_lin       = r_sync2;
    assign w_elem      = (r_cnt >= C_DASH_TH) ? ELEM_DASH : ELEM_DOT;
    assign w_cnt_inc   = (r_cnt == C_WORD_TH) ? r_cnt : r_cnt + C_ONE;
    // A TICK landing on the cycle a new phase starts belongs to that phase.
    assign w_cnt_start = TICK ? C_ONE : '0;

    // NOTE: RST is asynchronous, so it sits in the sensitivity list next to CLK.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pattern <= '0;
            r_len     <= '0;
            r_ovf     <= 1'b0;
            r_char    <= 8'h00;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            r_sync1 <= MORSE_IN;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_char  <= w_char_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
            if (w_emit_letter) begin
                r_pattern <= '0;
                r_len     <= '0;
                r_ovf     <= 1'b0;
            end else if (w_end_mark) begin
                if (r_len < C_MAX_LEN) begin
                    r_pattern <= {r_pattern[MAX_ELEM-2:0], w_elem};
                    r_len     <= r_len + 3'd1;
                end else begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = TICK ? w_cnt_inc : r_cnt;
        w_end_mark    = 1'b0;
        w_emit_letter = 1'b0;
        w_emit_space  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_lin) begin
                    w_state_nxt = ST_MARK;
                    w_cnt_nxt   = w_cnt_start;
                end
            end
            ST_MARK: begin
                if (!w_lin) begin
                    w_end_mark  = 1'b1;
                    w_state_nxt = ST_SPACE;
                    w_cnt_nxt   = w_cnt_start;
                end
            end
            ST_SPACE: begin
                // The threshold TICK wins over a simultaneous mark: the letter still goes out.
                if (TICK && (w_cnt_inc == C_LETTER_TH)) begin
                    w_emit_letter = 1'b1;
                    w_state_nxt   = w_lin ? ST_MARK : ST_GAP;
                    if (w_lin) w_cnt_nxt = '0;
                end else if (w_lin) begin
                    w_state_nxt = ST_MARK;
                    w_cnt_nxt   = w_cnt_start;
                end
            end
            ST_GAP: begin
                if (TICK && (w_cnt_inc == C_WORD_TH)) begin
                    w_emit_space = 1'b1;
                    w_state_nxt  = w_lin ? ST_MARK : ST_IDLE;
                    w_cnt_nxt    = '0;
                end else if (w_lin) begin
                    w_state_nxt = ST_MARK;
                    w_cnt_nxt   = w_cnt_start;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_valid_nxt = w_emit_letter || w_emit_space;
        w_err_nxt   = w_emit_letter && (r_ovf || !w_lut_hit);
        w_char_nxt  = r_char;
        if (w_emit_letter) begin
            w_char_nxt = w_err_nxt ? ASCII_UNKNOWN : w_lut_ascii;
        end else if (w_emit_space) begin
            w_char_nxt = ASCII_SPACE;
        end
    end

    assign CHAR  = r_char;
    assign VALID = r_valid;
    assign ERR   = r_err;
    assign BUSY  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Self-checking bench for morse_rx_decoder: line/tick stimulus is built as runs,
// and a run-level model predicts every output on every cycle.
module tb_morse_rx_decoder;

    localparam int D    = 4;
    localparam int ME   = 5;
    localparam int MAXC = 3000;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       TICK = 1'b0;
    logic       MORSE_IN = 1'b0;
    logic [7:0] CHAR;
    logic       VALID, ERR, BUSY;

    morse_rx_decoder #(
        .DOT_TICKS (D),
        .MAX_ELEM  (ME)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .TICK     (TICK),
        .MORSE_IN (MORSE_IN),
        .CHAR     (CHAR),
        .VALID    (VALID),
        .ERR      (ERR),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    bit         m_arr[MAXC+4];
    bit         t_arr[MAXC+4];
    bit         lin_arr[MAXC+4];
    bit         exp_valid[MAXC+4];
    bit         exp_err[MAXC+4];
    bit         exp_busy[MAXC+4];
    logic [7:0] exp_ech[MAXC+4];
    logic [7:0] exp_char[MAXC+4];
    int         n_cyc;
    bit         tick_rand;

    bit         elems[$];
    logic [7:0] model_chars[$];
    bit         model_errs[$];
    int         model_first;

    int         cur_c;
    bit         compare_en = 1'b0;
    string      cur_name = "init";

    string morse_tab[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                             ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                             "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                             "-----", ".----", "..---", "...--", "....-", ".....",
                             "-....", "--...", "---..", "----."};
    string alnum = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s cycle %0d: got %0h expected %0h", cur_name, what, cur_c, act, exp);
        end
    endtask

    // ---------------- stimulus construction ----------------
    task automatic begin_scn(input bit rnd);
        n_cyc     = 0;
        tick_rand = rnd;
    endtask

    task automatic push_run(input bit level, input int len);
        for (int k = 0; k < len; k++) begin
            if (n_cyc < MAXC) begin
                m_arr[n_cyc] = level;
                t_arr[n_cyc] = tick_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                n_cyc++;
            end
        end
    endtask

    task automatic push_letter(input string pat, input int gap);
        for (int i = 0; i < pat.len(); i++) begin
            push_run(1'b1, (pat[i] == 8'h2D) ? 3 * D : D);
            push_run(1'b0, (i < pat.len() - 1) ? D : gap);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic void emit_at(input int c, input bit is_space);
        string      key = "";
        logic [7:0] ch  = 8'h3F;
        bit         er  = 1'b1;
        if (is_space) begin
            ch = 8'h20;
            er = 1'b0;
        end else begin
            if (elems.size() <= ME) begin
                foreach (elems[k]) begin
                    if (elems[k]) key = {key, "-"};
                    else          key = {key, "."};
                end
                for (int i = 0; i < 36; i++) begin
                    if (morse_tab[i] == key) begin
                        ch = alnum[i];
                        er = 1'b0;
                    end
                end
            end
            elems.delete();
        end
        exp_valid[c] = 1'b1;
        exp_ech[c]   = ch;
        exp_err[c]   = er;
        model_chars.push_back(ch);
        model_errs.push_back(er);
        if (model_first < 0) model_first = c;
    endfunction

    // Walks the synchronised line as alternating mark/space runs, counting the
    // TICKs inside each run; a TICK on the first cycle of a mark that completes a
    // gap threshold belongs to the gap, not to the mark.
    function automatic void run_model();
        int a, b, e, ticks, sp, c;
        bit consumed, letter_done, word_done;
        logic [7:0] held;
        for (int i = 0; i < n_cyc; i++) begin
            lin_arr[i]   = (i >= 2) ? m_arr[i-2] : 1'b0;
            exp_valid[i] = 1'b0;
            exp_err[i]   = 1'b0;
            exp_busy[i]  = 1'b0;
            exp_ech[i]   = 8'h00;
        end
        elems.delete();
        model_chars.delete();
        model_errs.delete();
        model_first = -1;
        consumed    = 1'b0;
        c = 0;
        while (c < n_cyc && !lin_arr[c]) c++;
        while (c < n_cyc) begin
            a = c;
            ticks = 0;
            for (int i = a; i < n_cyc; i++) exp_busy[i] = 1'b1;
            b = a;
            while (b < n_cyc && lin_arr[b]) begin
                if (t_arr[b] && !(b == a && consumed)) ticks++;
                b++;
            end
            consumed = 1'b0;
            if (b >= n_cyc) break;
            elems.push_back(ticks >= 2 * D);
            sp = 0;
            letter_done = 1'b0;
            word_done   = 1'b0;
            e = b;
            while (e < n_cyc && !lin_arr[e]) begin
                if (t_arr[e] && !word_done) begin
                    sp++;
                    if (sp == 2 * D) begin
                        emit_at(e, 1'b0);
                        letter_done = 1'b1;
                    end else if (sp == 5 * D) begin
                        emit_at(e, 1'b1);
                        word_done = 1'b1;
                        for (int i = e; i < n_cyc; i++) exp_busy[i] = 1'b0;
                    end
                end
                e++;
            end
            if (e >= n_cyc) break;
            if (t_arr[e] && !letter_done && sp == 2 * D - 1) begin
                emit_at(e, 1'b0);
                consumed = 1'b1;
            end else if (t_arr[e] && letter_done && !word_done && sp == 5 * D - 1) begin
                emit_at(e, 1'b1);
                consumed = 1'b1;
            end
            c = e;
        end
        held = 8'h00;
        for (int i = 0; i < n_cyc; i++) begin
            if (exp_valid[i]) held = exp_ech[i];
            exp_char[i] = held;
        end
    endfunction

    // ---------------- driving and comparing ----------------
    task automatic run_scenario(input string name);
        run_model();
        compare_en = 1'b0;
        cur_name   = name;
        cur_c      = -1;
        @(negedge CLK);
        MORSE_IN = 1'b0;
        TICK     = 1'b0;
        RST      = 1'b1;
        #1;
        check("rst_valid", VALID, 0);
        check("rst_err",   ERR,   0);
        check("rst_busy",  BUSY,  0);
        check("rst_char",  CHAR,  0);
        @(negedge CLK);
        RST = 1'b0;
        for (int c = 0; c < n_cyc; c++) begin
            if (c > 0) @(negedge CLK);
            MORSE_IN   = m_arr[c];
            TICK       = t_arr[c];
            cur_c      = c;
            compare_en = 1'b1;
        end
        @(negedge CLK);
        compare_en = 1'b0;
        MORSE_IN   = 1'b0;
        TICK       = 1'b0;
    endtask

    always @(posedge CLK) begin
        #1;
        if (compare_en) begin
            check("valid", VALID, exp_valid[cur_c]);
            check("busy",  BUSY,  exp_busy[cur_c]);
            check("err",   ERR,   exp_err[cur_c]);
            check("char",  CHAR,  exp_char[cur_c]);
        end
    end

    task automatic pin(input string exp);
        check("pin_count", model_chars.size(), exp.len());
        for (int i = 0; i < exp.len(); i++) begin
            if (i < model_chars.size()) check("pin_char", model_chars[i], exp[i]);
        end
    endtask

    initial begin
        // Letter A with TICK every CLK, then a word gap.
        begin_scn(1'b0);
        push_run(1'b0, 3);
        push_letter(".-", 20);
        push_run(1'b0, 30);
        run_scenario("A");
        pin("A ");
        check("pin_first_valid_cycle", model_first, 32);

        // Dot/dash boundary: 7 ticks is a dot, 8 ticks is a dash.
        begin_scn(1'b0);
        push_run(1'b0, 3);
        push_run(1'b1, 7);
        push_run(1'b0, 12);
        push_run(1'b1, 8);
        push_run(1'b0, 24);
        push_run(1'b0, 30);
        run_scenario("boundary");
        pin("ET ");

        // SOS with 3-unit letter gaps, a word gap, then long idle.
        begin_scn(1'b0);
        push_run(1'b0, 3);
        push_letter("...", 3 * D);
        push_letter("---", 3 * D);
        push_letter("...", 7 * D);
        push_run(1'b0, 100 * D);
        run_scenario("SOS");
        pin("SOS ");

        // Overflow, unknown pattern, then a valid digit.
        begin_scn(1'b0);
        push_run(1'b0, 3);
        push_letter("......", 3 * D);
        push_letter("..--", 3 * D);
        push_letter(".....", 7 * D);
        push_run(1'b0, 30);
        run_scenario("errors");
        pin("??5 ");
        check("pin_err0", model_errs[0], 1);
        check("pin_err1", model_errs[1], 1);
        check("pin_err2", model_errs[2], 0);

        // Two elements of R, then reset mid-symbol, then K.
        begin_scn(1'b0);
        push_run(1'b0, 3);
        push_run(1'b1, D);
        push_run(1'b0, D);
        push_run(1'b1, 3 * D);
        push_run(1'b0, D);
        run_scenario("R_partial");
        pin("");
        begin_scn(1'b0);
        push_run(1'b0, 3);
        push_letter("-.-", 7 * D);
        push_run(1'b0, 30);
        run_scenario("K_after_reset");
        pin("K ");

        // Mark starting on the exact letter-threshold and word-threshold TICKs.
        begin_scn(1'b0);
        push_run(1'b0, 3);
        push_run(1'b1, D);
        push_run(1'b0, 2 * D - 1);
        push_run(1'b1, 2 * D + 1);
        push_run(1'b0, 6 * D);
        push_run(1'b1, D);
        push_run(1'b0, 5 * D - 1);
        push_run(1'b1, D);
        push_run(1'b0, 6 * D);
        push_run(1'b0, 30);
        run_scenario("simultaneous");
        pin("ET E E ");

        // Randomised runs around every threshold, with dense and sparse TICKs.
        for (int s = 0; s < 8; s++) begin
            int sc;
            begin_scn(s[0]);
            sc = s[0] ? 2 : 1;
            push_run(1'b0, $urandom_range(0, 5));
            for (int r = 0; r < 20; r++) begin
                int sel;
                if (s == 3 && r == 10) push_run(1'b1, 70);
                else                   push_run(1'b1, sc * $urandom_range(1, 16));
                sel = $urandom_range(0, 9);
                if (sel < 5)      push_run(1'b0, sc * $urandom_range(1, 10));
                else if (sel < 8) push_run(1'b0, sc * $urandom_range(6, 20));
                else              push_run(1'b0, sc * $urandom_range(18, 30));
            end
            push_run(1'b0, 60);
            run_scenario($sformatf("random%0d", s));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/morse_rx_decoder.md
Name: morse_rx_decoder

Overview:
- Receive side of the Morse link: samples the keyed line, measures mark/space durations in TICK units, and classifies each mark as dot or dash.
- Assembles elements into a symbol and decodes it to ASCII (A-Z, 0-9) when a letter gap is seen.
- Emits a space character when a word gap is seen.
- Sits between the line input (pin or loopback from the transmitter) and the character sink (UART/display).

Parameters:
- DOT_TICKS, 8, TICK pulses per dot unit (>=2); thresholds derive from it.
- MAX_ELEM, 5, maximum elements per symbol; defines pattern register width.

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous, active-high reset
- TICK  input  1  one-CLK timebase strobe; all duration counters advance only on TICK
- MORSE_IN  input  1  keyed line, 1 = mark; asynchronous to CLK
- CHAR  output  8  decoded ASCII; holds until next VALID
- VALID  output  1  one-CLK pulse, CHAR/ERR valid
- ERR  output  1  qualifies VALID: symbol overflow or unknown pattern
- BUSY  output  1  1 whenever state != IDLE

Behaviour:
- Reset is RST, asynchronous, active-high; clock is CLK. RST forces CHAR=8'h00, VALID=0, ERR=0, BUSY=0, state IDLE, counters/pattern/length/overflow cleared. RST mid-symbol discards the partial symbol; no VALID is emitted.
- Input sync: MORSE_IN passes through a 2-flop synchronizer, giving 2 CLK latency. All logic uses the synced value LIN.
- Thresholds:
  - DASH_TH = 2*DOT_TICKS.
  - LETTER_TH = 2*DOT_TICKS.
  - WORD_TH = 5*DOT_TICKS.
  - The duration counter saturates at WORD_TH and never wraps.
- Pattern: new element shifts in at the LSB (dot=0, dash=1), and LEN increments. The first element ends up in the MSB of the LEN used bits.
- IDLE: LIN=1 -> MARK, cnt=0.
- MARK: cnt++ on TICK.
  - On LIN=0: element = (cnt >= DASH_TH) ? dash : dot.
  - If LEN<MAX_ELEM, append the element. Otherwise set overflow and leave the pattern unchanged.
  - Then -> SPACE, cnt=0.
  - A stuck key stays in MARK with cnt saturated.
- SPACE: cnt++ on TICK.
  - LIN=1 before cnt reaches LETTER_TH -> MARK, cnt=0 (same letter).
  - When cnt reaches LETTER_TH: emit the letter. The cycle after that TICK, VALID=1 and CHAR=LUT(LEN,pattern).
  - ERR=1 with CHAR=8'h3F if overflow or the pattern is not in the LUT.
  - Clear pattern/LEN/overflow, then -> GAP; cnt keeps counting.
  - Simultaneous threshold TICK and LIN=1: the letter is still emitted, then the next state is MARK with cnt=0.
- GAP: cnt++ on TICK.
  - LIN=1 -> MARK, cnt=0 (new letter, no space emitted).
  - When cnt reaches WORD_TH: emit VALID with CHAR=8'h20, ERR=0, then -> IDLE. Simultaneous LIN=1 gives the same priority rule as SPACE.
- Only IDLE emits nothing on silence, so exactly one space is emitted per gap.
- VALID is never asserted on consecutive cycles. ERR is 0 whenever VALID=0.

Decomposition:
- Package morse_pkg holds:
  - element encoding constants (DOT=0, DASH=1);
  - ASCII constants (SPACE 8'h20, UNKNOWN 8'h3F);
  - state encoding (IDLE, MARK, SPACE, GAP).
- The transmitter shares this package.
- Sub-module morse_lut: combinational; inputs LEN[2:0] and pattern[MAX_ELEM-1:0]; outputs ASCII[7:0] and hit. Covers A-Z and 0-9.

Test Plan:
1. Letter 'A', DOT_TICKS=4, TICK every CLK: mark 4, space 4, mark 12, space 8 -> one VALID, CHAR=8'h41, ERR=0, 2+1 CLK after the 8th space TICK.
2. Dot/dash boundary, DOT_TICKS=4: mark 7 ticks -> dot ('E', 8'h45); mark 8 ticks -> dash ('T', 8'h54).
3. "SOS" with 3-unit letter gaps, then 7-unit silence -> VALID sequence 8'h53, 8'h4F, 8'h53, 8'h20, then BUSY=0. No second 8'h20 after 100 more idle units.
4. Errors:
   - six dots -> VALID, ERR=1, CHAR=8'h3F;
   - pattern ..-- (LEN4, 0011) -> ERR=1, CHAR=8'h3F;
   - next "5" (.....) -> CHAR=8'h35, ERR=0.
5. Reset mid-symbol: after 2 elements of 'R', pulse RST for 1 CLK between TICKs -> no VALID, all outputs 0. A following 'K' decodes to 8'h4B.
6. Simultaneous event: LIN rises on the exact TICK where the space count hits LETTER_TH -> letter VALID still emitted, next mark counted from 0 as the first element of the next letter.
